iq_nco_mod_mc: RTL and testbench

//  Multi-channel, time-multiplexed NCO + IQ modulator; parametrised successor of the single-channel IQ mod/demod.
//  Per-channel tuning word and phase offset; shared sine LUT produces cos (I) and sin (Q) carriers.

---
 rtl/iq_nco_mod_mc.sv | 166 ++++++++++++++++
 tb/tb_iq_nco_mod_mc.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_nco_mod_mc.sv
// Time-multiplexed multi-channel NCO + IQ modulator: per beat, y = I*cos - Q*sin on that channel's phase.
// Latency: beat accepted at edge k is on out_* after edge k+4; stalls add cycle-for-cycle.
// Backpressure: every stage freezes while out_valid & !out_ready; in_ready drops with it.
module iq_nco_mod_mc #(
    parameter int NUM_CH     = 4,
    parameter int FTW_W      = 8,
    parameter int PHASE_W    = 10,
    parameter int LUT_ADDR_W = 8,
    parameter int CARRIER_W  = 24,
    parameter int DATA_W     = 16,
    parameter int OUT_W      = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_we,
    input  logic [CH_W-1:0]             cfg_ch,
    input  logic [FTW_W-1:0]            cfg_ftw,
    input  logic [LUT_ADDR_W-1:0]       cfg_phase_off,
    input  logic                        cfg_sync,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CH_W-1:0]             in_ch,
    input  logic signed [DATA_W-1:0]    in_i,
    input  logic signed [DATA_W-1:0]    in_q,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CH_W-1:0]             out_ch,
    output logic signed [CARRIER_W-1:0] out_i_carrier,
    output logic signed [CARRIER_W-1:0] out_q_carrier,
    output logic signed [OUT_W-1:0]     out_mod
);

    localparam int LUT_N  = 1 << LUT_ADDR_W;
    localparam int PH_SH  = PHASE_W - LUT_ADDR_W;
    localparam int PROD_W = DATA_W + CARRIER_W;
    localparam int SUM_W  = PROD_W + 1;

    // Full-wave table, entry n = round(peak * sin(2*pi*n/LUT_N)), fixed at elaboration.
    function automatic logic signed [CARRIER_W-1:0] sine_entry(input int n);
        real peak;
        real ang;
        peak = real'((longint'(1) <<< (CARRIER_W - 1)) - 1);
        ang  = 2.0 * 3.14159265358979323846 * real'(n) / real'(LUT_N);
        return CARRIER_W'(longint'(peak * $sin(ang)));
    endfunction

    logic signed [CARRIER_W-1:0] sine_rom [LUT_N];

    for (genvar n = 0; n < LUT_N; n++) begin : g_rom
        assign sine_rom[n] = sine_entry(n);
    end

    logic                  adv;
    logic                  accept;
    logic                  in_ch_ok;
    logic                  cfg_ch_ok;
    logic [PHASE_W-1:0]    acc [NUM_CH];
    logic [FTW_W-1:0]      ftw [NUM_CH];
    logic [LUT_ADDR_W-1:0] off [NUM_CH];
    logic [PHASE_W-1:0]    phase_sum;

    if (NUM_CH == (1 << CH_W)) begin : g_ch_full
        assign in_ch_ok  = 1'b1;
        assign cfg_ch_ok = 1'b1;
    end else begin : g_ch_part
        assign in_ch_ok  = (in_ch < CH_W'(NUM_CH));
        assign cfg_ch_ok = (cfg_ch < CH_W'(NUM_CH));
    end

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && !reset;
    assign accept    = in_valid && in_ready;
    assign phase_sum = acc[in_ch] + (PHASE_W'(off[in_ch]) << PH_SH);

    // Sync outranks the increment; config writes land after the beat that sees the old values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
                ftw[c] <= '0;
                off[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cfg_sync)
                    acc[c] <= '0;
                else if (accept && in_ch_ok && in_ch == CH_W'(c))
                    acc[c] <= acc[c] + PHASE_W'(ftw[c]);
                if (cfg_we && cfg_ch_ok && cfg_ch == CH_W'(c)) begin
                    ftw[c] <= cfg_ftw;
                    off[c] <= cfg_phase_off;
                end
            end
        end
    end

    logic                        s1_vld, s2_vld, s3_vld, s4_vld;
    logic [CH_W-1:0]             s1_ch, s2_ch, s3_ch, s4_ch;
    logic [LUT_ADDR_W-1:0]       s1_addr;
    logic signed [DATA_W-1:0]    s1_i, s1_q, s2_i, s2_q;
    logic signed [CARRIER_W-1:0] s2_sin, s2_cos, s3_sin, s3_cos, s4_sin, s4_cos;
    logic signed [PROD_W-1:0]    s3_pi, s3_pq;
    logic signed [SUM_W-1:0]     s4_sum;
    logic signed [SUM_W-1:0]     sum_sh;
    logic                        sum_ovf;
    logic signed [OUT_W-1:0]     sum_sat;

    // After the floor shift only OUT_W bits are legal; any disagreement above the sign bit is overflow.
    assign sum_sh  = s4_sum >>> (CARRIER_W - 1);
    assign sum_ovf = !(&sum_sh[SUM_W-1:OUT_W-1]) && (|sum_sh[SUM_W-1:OUT_W-1]);
    assign sum_sat = !sum_ovf ? sum_sh[OUT_W-1:0]
                   : (sum_sh[SUM_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld <= 1'b0; s2_vld <= 1'b0; s3_vld <= 1'b0; s4_vld <= 1'b0;
            s1_ch  <= '0;   s2_ch  <= '0;   s3_ch  <= '0;   s4_ch  <= '0;
            s1_addr <= '0;
            s1_i   <= '0;   s1_q   <= '0;   s2_i   <= '0;   s2_q   <= '0;
            s2_sin <= '0;   s2_cos <= '0;   s3_sin <= '0;   s3_cos <= '0;
            s4_sin <= '0;   s4_cos <= '0;
            s3_pi  <= '0;   s3_pq  <= '0;   s4_sum <= '0;
            out_valid     <= 1'b0;
            out_ch        <= '0;
            out_i_carrier <= '0;
            out_q_carrier <= '0;
            out_mod       <= '0;
        end else if (adv) begin
            s1_vld  <= accept && in_ch_ok;
            s1_ch   <= in_ch;
            s1_addr <= phase_sum[PHASE_W-1 -: LUT_ADDR_W];
            s1_i    <= in_i;
            s1_q    <= in_q;

            s2_vld <= s1_vld;
            s2_ch  <= s1_ch;
            s2_sin <= sine_rom[s1_addr];
            s2_cos <= sine_rom[s1_addr + LUT_ADDR_W'(LUT_N / 4)];
            s2_i   <= s1_i;
            s2_q   <= s1_q;

            s3_vld <= s2_vld;
            s3_ch  <= s2_ch;
            s3_sin <= s2_sin;
            s3_cos <= s2_cos;
            s3_pi  <= PROD_W'(s2_i) * PROD_W'(s2_cos);
            s3_pq  <= PROD_W'(s2_q) * PROD_W'(s2_sin);

            s4_vld <= s3_vld;
            s4_ch  <= s3_ch;
            s4_sin <= s3_sin;
            s4_cos <= s3_cos;
            s4_sum <= SUM_W'(s3_pi) - SUM_W'(s3_pq);

            out_valid <= s4_vld;
            if (s4_vld) begin
                out_ch        <= s4_ch;
                out_i_carrier <= s4_cos;
                out_q_carrier <= s4_sin;
                out_mod       <= sum_sat;
            end
        end
    end

endmodule

// File: tb/tb_iq_nco_mod_mc.sv
// Bench for iq_nco_mod_mc: directed cases plus a randomized stream against a phase/trig reference model.
module tb_iq_nco_mod_mc;

    localparam int     NUM_CH = 4;
    localparam int     CH_W   = 2;
    localparam real    PI     = 3.14159265358979323846;
    localparam longint PEAK   = 8388607;
    localparam longint C45    = 5931641;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                cfg_we = 1'b0;
    logic [CH_W-1:0]     cfg_ch = '0;
    logic [7:0]          cfg_ftw = '0;
    logic [7:0]          cfg_phase_off = '0;
    logic                cfg_sync = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [CH_W-1:0]     in_ch = '0;
    logic signed [15:0]  in_i = '0;
    logic signed [15:0]  in_q = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [CH_W-1:0]     out_ch;
    logic signed [23:0]  out_i_carrier;
    logic signed [23:0]  out_q_carrier;
    logic signed [15:0]  out_mod;

    always #5 clk = ~clk;

    iq_nco_mod_mc dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_ftw(cfg_ftw),
        .cfg_phase_off(cfg_phase_off), .cfg_sync(cfg_sync),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_i(in_i), .in_q(in_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_i_carrier(out_i_carrier), .out_q_carrier(out_q_carrier), .out_mod(out_mod)
    );

    typedef struct {
        int     ch;
        longint icar;
        longint qcar;
        longint md;
    } beat_t;

    beat_t  exp_q[$];
    beat_t  obs_q[$];
    int     m_acc[NUM_CH];
    int     m_ftw[NUM_CH];
    int     m_off[NUM_CH];
    int     n_checks = 0;
    int     n_errors = 0;
    int     tick_no = 0;
    int     last_acc_tick = 0;
    int     first_out_tick = -1;
    bit     last_acc = 1'b0;
    bit     prev_stall = 1'b0;
    longint prev_mod, prev_icar, prev_qcar;
    int     prev_ch;

    task automatic chk(input string tag, input logic signed [63:0] got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sin_ref(input int a);
        return longint'(real'(PEAK) * $sin(2.0 * PI * real'(a) / 256.0));
    endfunction

    function automatic longint cos_ref(input int a);
        return longint'(real'(PEAK) * $cos(2.0 * PI * real'(a) / 256.0));
    endfunction

    function automatic longint mod_ref(input longint i, input longint q, input longint c, input longint s);
        longint p, f;
        p = i * c - q * s;
        f = p / 8388608;
        if ((p % 8388608) != 0 && p < 0) f = f - 1;
        if (f > 32767) f = 32767;
        else if (f < -32768) f = -32768;
        return f;
    endfunction

    // One cycle: observe at negedge+1, update the model, then move to the next negedge.
    task automatic tick();
        beat_t b, e;
        int    c, a;
        #1;
        last_acc = 1'b0;
        if (reset) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_mod", out_mod, 0);
            chk("rst_in_ready", in_ready, 0);
            exp_q.delete();
            for (int k = 0; k < NUM_CH; k++) begin
                m_acc[k] = 0; m_ftw[k] = 0; m_off[k] = 0;
            end
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_mod", out_mod, prev_mod);
                chk("hold_icar", out_i_carrier, prev_icar);
                chk("hold_qcar", out_q_carrier, prev_qcar);
                chk("hold_ch", out_ch, prev_ch);
            end
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (in_valid && in_ready) begin
                last_acc = 1'b1;
                last_acc_tick = tick_no;
                c = int'(in_ch);
                if (c < NUM_CH) begin
                    a = ((m_acc[c] + m_off[c] * 4) % 1024) / 4;
                    e.ch   = c;
                    e.icar = cos_ref(a);
                    e.qcar = sin_ref(a);
                    e.md   = mod_ref(in_i, in_q, e.icar, e.qcar);
                    exp_q.push_back(e);
                    m_acc[c] = (m_acc[c] + m_ftw[c]) % 1024;
                end
            end
            if (out_valid && out_ready) begin
                b.ch = int'(out_ch); b.icar = out_i_carrier; b.qcar = out_q_carrier; b.md = out_mod;
                obs_q.push_back(b);
                if (first_out_tick < 0) first_out_tick = tick_no;
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_ch", out_ch, e.ch);
                    chk("i_carrier", out_i_carrier, e.icar);
                    chk("q_carrier", out_q_carrier, e.qcar);
                    chk("mod", out_mod, e.md);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_mod = out_mod; prev_icar = out_i_carrier; prev_qcar = out_q_carrier; prev_ch = int'(out_ch);
            if (cfg_we) begin
                m_ftw[int'(cfg_ch)] = int'(cfg_ftw);
                m_off[int'(cfg_ch)] = int'(cfg_phase_off);
            end
            if (cfg_sync)
                for (int k = 0; k < NUM_CH; k++) m_acc[k] = 0;
        end
        tick_no++;
        @(negedge clk);
    endtask

    task automatic cfg(input int ch, input int f, input int o);
        cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_ftw = 8'(f); cfg_phase_off = 8'(o);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic sync();
        cfg_sync = 1'b1;
        tick();
        cfg_sync = 1'b0;
    endtask

    task automatic send(input int ch, input int i, input int q);
        in_valid = 1'b1; in_ch = CH_W'(ch); in_i = 16'(i); in_q = 16'(q);
        for (int n = 0; n < 20; n++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 64) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        repeat (6) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at tick %0d", tick_no);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        @(negedge clk);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // ch0 ftw=128, full-scale I: carrier walks a quarter-wave per pair of beats
        cfg(0, 128, 0);
        obs_q.delete();
        first_out_tick = -1;
        send(0, 16'h7FFF, 0);
        t0 = last_acc_tick;
        for (int k = 1; k < 8; k++) send(0, 16'h7FFF, 0);
        drain();
        // accept seen one negedge before its edge, output one negedge after edge k+4
        chk("latency_edges", first_out_tick - t0 - 1, 4);
        chk("t2_count", obs_q.size(), 8);
        chk("t2_icar0", obs_q[0].icar, PEAK);
        chk("t2_icar1", obs_q[1].icar, C45);
        chk("t2_icar2", obs_q[2].icar, 0);
        chk("t2_mod0", obs_q[0].md, 32766);
        chk("t2_mod4", obs_q[4].md, -32767);

        // interleaved channels with different steps
        cfg(1, 64, 0);
        sync();
        obs_q.delete();
        for (int k = 0; k < 8; k++) send(k % 2, 16'h4000, int'(16'($urandom)));
        drain();
        chk("t3_ch0", obs_q[0].ch, 0);
        chk("t3_ch1", obs_q[1].ch, 1);
        chk("t3_ch0_a64", obs_q[4].qcar, PEAK);
        chk("t3_ch1_a32", obs_q[5].qcar, C45);

        // offset-only channel driven into both saturation rails
        cfg(2, 0, 32);
        obs_q.delete();
        send(2, 16'h7FFF, 16'h8000);
        send(2, 16'h8000, 16'h7FFF);
        drain();
        chk("t5_sat_hi", obs_q[0].md, 32767);
        chk("t5_sat_lo", obs_q[1].md, -32768);

        // config write and sync landing on the same cycle as a beat
        sync();
        cfg(0, 128, 0);
        obs_q.delete();
        cfg_we = 1'b1; cfg_ch = 0; cfg_ftw = 16; cfg_phase_off = 0;
        send(0, 16'h7FFF, 16'h7FFF);
        cfg_we = 1'b0;
        send(0, 16'h7FFF, 16'h7FFF);
        send(0, 16'h7FFF, 16'h7FFF);
        cfg_sync = 1'b1;
        send(0, 16'h7FFF, 16'h7FFF);
        cfg_sync = 1'b0;
        send(0, 16'h7FFF, 16'h7FFF);
        send(1, 16'h7FFF, 16'h7FFF);
        drain();
        chk("t6_old_ftw", obs_q[1].qcar, C45);
        chk("t6_new_ftw", obs_q[2].qcar, sin_ref(36));
        chk("t6_presync", obs_q[3].qcar, sin_ref(40));
        chk("t6_sync_i", obs_q[4].icar, PEAK);
        chk("t6_sync_q", obs_q[4].qcar, 0);
        chk("t6_sync_ch1", obs_q[5].qcar, 0);

        // randomized stream with backpressure and live reconfiguration
        for (int n = 0; n < 500; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_ch     = CH_W'($urandom);
            in_i      = 16'($urandom);
            in_q      = 16'($urandom);
            out_ready = (n >= 200 && n < 203) ? 1'b0 : ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 19) == 0);
            cfg_ch    = CH_W'($urandom);
            cfg_ftw   = 8'($urandom);
            cfg_phase_off = 8'($urandom);
            cfg_sync  = ($urandom_range(0, 49) == 0);
            tick();
        end
        in_valid = 1'b0; cfg_we = 1'b0; cfg_sync = 1'b0;
        drain();

        // reset asserted while beats are in flight and output is stalled
        cfg(3, 8, 0);
        in_valid = 1'b1; in_ch = 3; out_ready = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        obs_q.delete();
        repeat (8) tick();
        chk("rst_no_output", obs_q.size(), 0);
        send(0, 16'h7FFF, 16'h7FFF);
        drain();
        chk("rst_count", obs_q.size(), 1);
        chk("rst_phase0_i", obs_q[0].icar, PEAK);
        chk("rst_phase0_q", obs_q[0].qcar, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
